// File: rtl/arb2_burst_sel_pkg.sv
// Shared definitions for the two-channel burst arbiter.
// Holds the FSM state encodings and the channel identifiers.
// No logic lives here; it is imported by the arbiter and its picker.
package arb2_burst_sel_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01
  } state_e;

  // Channel identifiers; also the value driven onto the mux select
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/arb2_burst_sel_rr_pick2.sv
// Two-way round-robin picker: chooses a winner among req0/req1 given the last winner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module arb2_burst_sel_rr_pick2
  import arb2_burst_sel_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,   // channel that won last time
  output logic o_win,   // winning channel, meaningful only when o_any
  output logic o_any
);

  assign o_any = i_req0 | i_req1;

  // A tie goes to the channel that did not win last; otherwise the lone requester wins.
  assign o_win = (i_req0 & i_req1) ? ~i_ptr : (i_req1 ? CH1 : CH0);

endmodule

// File: rtl/arb2_burst_sel.sv
// Round-robin burst arbiter steering a downstream 2:1 mux; grants locked bursts of BURST beats.
// Latency: grant/select one cycle after request; beat valid/ack combinational within the burst.
// Backpressure: out_ready low holds the beat (no ack, no count); an idle grantee is released after TIMEOUT cycles.
module arb2_burst_sel
  import arb2_burst_sel_pkg::*;
#(
  parameter int BURST   = 4,
  parameter int CNT_W   = 2,
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic out_ready,
  output logic s,
  output logic gnt0,
  output logic gnt1,
  output logic out_valid,
  output logic ack0,
  output logic ack1
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
  localparam logic [TO_W-1:0]  IDLE_MAX  = TO_W'(TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  logic             r_s, w_s_nxt;
  logic             r_gnt0, w_gnt0_nxt;
  logic             r_gnt1, w_gnt1_nxt;
  logic             r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [TO_W-1:0]  r_idle, w_idle_nxt;

  logic w_win;
  logic w_any;
  logic w_req_g;
  logic w_acc;

  arb2_burst_sel_rr_pick2 u_pick (
    .i_req0 (req0),
    .i_req1 (req1),
    .i_ptr  (r_ptr),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // The select register always names the grantee while a burst is open.
  assign w_req_g   = (r_s == CH1) ? req1 : req0;
  assign out_valid = (r_state == ST_BUSY) & w_req_g;
  assign w_acc     = out_valid & out_ready;
  assign ack0      = w_acc & (r_s == CH0);
  assign ack1      = w_acc & (r_s == CH1);

  assign s    = r_s;
  assign gnt0 = r_gnt0;
  assign gnt1 = r_gnt1;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= CH0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_ptr   <= CH1;
      r_cnt   <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

  // Next-state logic: grant in IDLE, count beats and idle cycles in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_gnt0_nxt  = r_gnt0;
    w_gnt1_nxt  = r_gnt1;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_idle_nxt  = r_idle;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_BUSY;
          w_s_nxt     = w_win;
          w_gnt0_nxt  = (w_win == CH0);
          w_gnt1_nxt  = (w_win == CH1);
          w_ptr_nxt   = w_win;
          w_cnt_nxt   = LAST_BEAT;
          w_idle_nxt  = '0;
        end
      end
      ST_BUSY: begin
        if (w_acc) begin
          w_idle_nxt = '0;
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
            w_gnt0_nxt  = 1'b0;
            w_gnt1_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end else if (!w_req_g) begin
          if (r_idle == IDLE_MAX) begin
            // Grantee went quiet too long; ptr still names it so the peer wins the next tie.
            w_state_nxt = ST_IDLE;
            w_gnt0_nxt  = 1'b0;
            w_gnt1_nxt  = 1'b0;
            w_idle_nxt  = '0;
          end else begin
            w_idle_nxt = r_idle + 1'b1;
          end
        end else begin
          // Beat offered but consumer stalled: hold, and the grantee is not idle.
          w_idle_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arb2_burst_sel.sv
// Bench for the burst arbiter: directed scenarios plus randomized traffic.
// Each cycle the observed outputs are compared against a burst-level reference model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_arb2_burst_sel;

  localparam int BURST   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic out_ready = 1'b0;
  logic s, gnt0, gnt1, out_valid, ack0, ack1;

  int checks = 0;
  int failures = 0;

  // {s, gnt0, gnt1, out_valid, ack0, ack1}
  logic [5:0] obs_vec;
  logic [5:0] exp_vec;
  assign obs_vec = {s, gnt0, gnt1, out_valid, ack0, ack1};

  // Reference model: who owns the burst, beats accepted so far, idle run length.
  int m_own  = -1;
  int m_acks = 0;
  int m_idle = 0;
  int m_last = 1;
  int m_sel  = 0;

  always #5 clk = ~clk;

  arb2_burst_sel #(
    .BURST   (BURST),
    .CNT_W   (2),
    .TIMEOUT (TIMEOUT),
    .TO_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .out_ready (out_ready),
    .s         (s),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .ack0      (ack0),
    .ack1      (ack1)
  );

  function automatic logic own_req(input int own, input logic r0, input logic r1);
    if (own == 0) return r0;
    if (own == 1) return r1;
    return 1'b0;
  endfunction

  function automatic logic [5:0] model_out(input int own, input int sel,
                                           input logic r0, input logic r1, input logic rdy);
    logic v;
    logic a;
    v = (own >= 0) && own_req(own, r0, r1);
    a = v && rdy;
    return {sel[0], own == 0, own == 1, v, a && (own == 0), a && (own == 1)};
  endfunction

  // Apply inputs for one cycle and compute what the outputs must be.
  task automatic drive(input logic r0, input logic r1, input logic rdy, input logic rs);
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    out_ready = rdy;
    rst = rs;
    #1;
    exp_vec = model_out(m_own, m_sel, r0, r1, rdy);
  endtask

  // Move the model across the coming rising edge, then let the edge happen.
  task automatic advance();
    logic rq;
    int w;
    rq = own_req(m_own, req0, req1);
    if (rst) begin
      m_own = -1; m_acks = 0; m_idle = 0; m_last = 1; m_sel = 0;
    end else if (m_own < 0) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
        m_own = w; m_sel = w; m_last = w; m_acks = 0; m_idle = 0;
      end
    end else if (rq && out_ready) begin
      m_acks++;
      m_idle = 0;
      if (m_acks == BURST) m_own = -1;
    end else if (!rq) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_own = -1;
        m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1); advance();
    drive(0, 0, 0, 1); advance();
    drive(1, 1, 1, 0);
    checks++;
    if (obs_vec !== 6'b000000) begin
      failures++;
      $display("FAIL reset_state observed=%b expected=%b", obs_vec, 6'b000000);
    end
    advance();
    drive(1, 1, 1, 0);
    checks++;
    if (obs_vec !== 6'b010110) begin
      failures++;
      $display("FAIL reset_first_grant observed=%b expected=%b", obs_vec, 6'b010110);
    end
    advance();
  endtask

  task automatic test_single_burst();
    logic [5:0] ack_seq;
    logic [5:0] gnt_seq;
    drive(0, 0, 0, 1); advance();
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 1, 0);
      ack_seq[c] = ack0;
      gnt_seq[c] = gnt0;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL single_burst_c%0d observed=%b expected=%b", c, obs_vec, exp_vec);
      end
      advance();
    end
    checks++;
    if (ack_seq !== 6'b011110) begin
      failures++;
      $display("FAIL single_burst_ack0_seq observed=%b expected=%b", ack_seq, 6'b011110);
    end
    checks++;
    if (gnt_seq !== 6'b011110) begin
      failures++;
      $display("FAIL single_burst_gnt0_seq observed=%b expected=%b", gnt_seq, 6'b011110);
    end
  endtask

  task automatic test_alternate();
    int n0 = 0;
    int n1 = 0;
    logic [3:0] s_at_grant;
    drive(0, 0, 0, 1); advance();
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 1, 0);
      n0 += int'(ack0);
      n1 += int'(ack1);
      if (c % 5 == 1) s_at_grant[c / 5] = s;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL alternate_c%0d observed=%b expected=%b", c, obs_vec, exp_vec);
      end
      advance();
    end
    checks++;
    if (s_at_grant !== 4'b1010) begin
      failures++;
      $display("FAIL alternate_grant_order observed=%b expected=%b", s_at_grant, 4'b1010);
    end
    checks++;
    if (n0 != 8 || n1 != 8) begin
      failures++;
      $display("FAIL alternate_ack_counts observed=%0d/%0d expected=8/8", n0, n1);
    end
  endtask

  task automatic test_stall();
    int n0 = 0;
    int n1 = 0;
    logic g7, g8;
    drive(0, 0, 0, 1); advance();
    drive(0, 1, 0, 0); advance();
    for (int c = 1; c <= 8; c++) begin
      drive(1, 1, (c % 2) == 1, 0);
      n0 += int'(ack0);
      n1 += int'(ack1);
      if (c == 7) g7 = gnt1;
      if (c == 8) g8 = gnt1;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL stall_c%0d observed=%b expected=%b", c, obs_vec, exp_vec);
      end
      advance();
    end
    checks++;
    if (n1 != 4 || n0 != 0) begin
      failures++;
      $display("FAIL stall_ack_counts observed=ack1:%0d ack0:%0d expected=ack1:4 ack0:0", n1, n0);
    end
    checks++;
    if ({g7, g8} !== 2'b10) begin
      failures++;
      $display("FAIL stall_burst_end observed=%b expected=%b", {g7, g8}, 2'b10);
    end
  endtask

  task automatic test_timeout();
    logic g9, g10;
    drive(0, 0, 0, 1); advance();
    drive(1, 0, 1, 0); advance();
    drive(1, 0, 1, 0); advance();
    for (int c = 2; c <= 9; c++) begin
      drive(0, 1, 1, 0);
      if (c == 9) g9 = gnt0;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL timeout_c%0d observed=%b expected=%b", c, obs_vec, exp_vec);
      end
      advance();
    end
    drive(1, 1, 1, 0);
    g10 = gnt0;
    advance();
    drive(1, 1, 1, 0);
    checks++;
    if ({g9, g10} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_release observed=%b expected=%b", {g9, g10}, 2'b10);
    end
    checks++;
    if (obs_vec !== 6'b101101) begin
      failures++;
      $display("FAIL timeout_next_grant observed=%b expected=%b", obs_vec, 6'b101101);
    end
    advance();
  endtask

  task automatic test_reset_mid_burst();
    int n1 = 0;
    drive(0, 0, 0, 1); advance();
    drive(0, 1, 1, 0); advance();
    drive(0, 1, 1, 0); advance();
    drive(0, 1, 1, 0); advance();
    drive(0, 1, 1, 1); advance();
    drive(0, 1, 1, 0);
    checks++;
    if (obs_vec !== 6'b000000) begin
      failures++;
      $display("FAIL midreset_state observed=%b expected=%b", obs_vec, 6'b000000);
    end
    advance();
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 1, 0);
      n1 += int'(ack1);
      checks++;
      if (c == 0 && obs_vec !== 6'b101101) begin
        failures++;
        $display("FAIL midreset_regrant observed=%b expected=%b", obs_vec, 6'b101101);
      end
      advance();
    end
    checks++;
    if (n1 != BURST) begin
      failures++;
      $display("FAIL midreset_burst_len observed=%0d expected=%0d", n1, BURST);
    end
  endtask

  task automatic test_random();
    logic r0, r1, rdy, rs;
    drive(0, 0, 0, 1); advance();
    for (int c = 0; c < 3000; c++) begin
      r0  = ($urandom_range(0, 9) < 7);
      r1  = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 7);
      rs  = ($urandom_range(0, 299) == 0);
      drive(r0, r1, rdy, rs);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL random_c%0d observed=%b expected=%b", c, obs_vec, exp_vec);
      end
      checks++;
      if ((gnt0 & gnt1) || ((gnt0 | gnt1) && (s !== gnt1))) begin
        failures++;
        $display("FAIL random_invariant_c%0d observed=s:%b g0:%b g1:%b expected=exclusive grants, s==gnt1",
                 c, s, gnt0, gnt1);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_alternate();
    test_stall();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
